// File: rtl/arbitro_escritura_breg.sv
// Register-file write-port arbiter (ALU vs. load) with a pending-write scoreboard.
// Optional macro ARBITRO_RR_EN selects round-robin arbitration instead of fixed A-over-M priority.
module arbitro_escritura_breg #(
    parameter int unsigned ANCHO = 32,
    parameter int unsigned NREG  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_a,
    input  logic [4:0]       dir_a,
    input  logic [ANCHO-1:0] dato_a,
    output logic             ack_a,
    input  logic             req_m,
    input  logic [4:0]       dir_m,
    input  logic [ANCHO-1:0] dato_m,
    output logic             ack_m,
    input  logic             reserva,
    input  logic [4:0]       dirres,
    input  logic [4:0]       dirlec1,
    input  logic [4:0]       dirlec2,
    output logic             ocupado1,
    output logic             ocupado2,
    output logic             enesc,
    output logic [4:0]       diresc,
    output logic [ANCHO-1:0] datoesc,
    output logic             err_sin_reserva
);

    typedef enum logic [0:0] {StLibre, StEscribe} estado_e;

    estado_e          estado_q, estado_d;
    logic             ack_a_q, ack_m_q;
    logic [4:0]       diresc_q;
    logic [ANCHO-1:0] datoesc_q;
    logic [NREG-1:0]  sb_q, sb_d;
    logic             err_q, err_d;

    logic             eleg_a, eleg_m;
    logic             gnt_a, gnt_m, gnt;
    logic [4:0]       dir_g;
    logic [ANCHO-1:0] dato_g;
    logic             escribe_g;

    // A requester whose ack is high this cycle cannot be granted again at this edge.
    assign eleg_a = req_a & ~ack_a_q;
    assign eleg_m = req_m & ~ack_m_q;

`ifdef ARBITRO_RR_EN
    logic ptr_q;  // 0: A preferred, 1: M preferred

    assign gnt_a = eleg_a & (~eleg_m | ~ptr_q);
    assign gnt_m = eleg_m & (~eleg_a | ptr_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else if (gnt_a) begin
            ptr_q <= 1'b1;
        end else if (gnt_m) begin
            ptr_q <= 1'b0;
        end
    end
`else
    assign gnt_a = eleg_a;
    assign gnt_m = eleg_m & ~eleg_a;
`endif

    assign gnt       = gnt_a | gnt_m;
    assign dir_g     = gnt_a ? dir_a : dir_m;
    assign dato_g    = gnt_a ? dato_a : dato_m;
    assign escribe_g = gnt & (dir_g != 5'd0);

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q <= StLibre;
        end else begin
            estado_q <= estado_d;
        end
    end

    // FSM: next state
    always_comb begin
        estado_d = StLibre;
        unique case (estado_q)
            StLibre:   estado_d = escribe_g ? StEscribe : StLibre;
            StEscribe: estado_d = escribe_g ? StEscribe : StLibre;
            default:   estado_d = StLibre;
        endcase
    end

    // FSM: outputs
    always_comb begin
        enesc = 1'b0;
        unique case (estado_q)
            StLibre:   enesc = 1'b0;
            StEscribe: enesc = 1'b1;
            default:   enesc = 1'b0;
        endcase
    end

    // Clear on write completion first, so a same-edge reservation wins.
    always_comb begin
        sb_d = sb_q;
        if (enesc) begin
            sb_d[diresc_q] = 1'b0;
        end
        if (reserva && (dirres != 5'd0)) begin
            sb_d[dirres] = 1'b1;
        end
        sb_d[0] = 1'b0;
    end

    assign err_d = err_q | (escribe_g & ~sb_q[dir_g]);

    always_ff @(posedge clk) begin
        if (rst) begin
            ack_a_q   <= 1'b0;
            ack_m_q   <= 1'b0;
            diresc_q  <= 5'd0;
            datoesc_q <= '0;
            sb_q      <= '0;
            err_q     <= 1'b0;
        end else begin
            ack_a_q <= gnt_a;
            ack_m_q <= gnt_m;
            if (gnt) begin
                diresc_q  <= dir_g;
                datoesc_q <= dato_g;
            end
            sb_q  <= sb_d;
            err_q <= err_d;
        end
    end

    assign ack_a           = ack_a_q;
    assign ack_m           = ack_m_q;
    assign diresc          = diresc_q;
    assign datoesc         = datoesc_q;
    assign err_sin_reserva = err_q;
    assign ocupado1        = sb_q[dirlec1];
    assign ocupado2        = sb_q[dirlec2];

endmodule

// File: tb/tb_arbitro_escritura_breg.sv
// Directed bench for arbitro_escritura_breg: per-cycle reference model plus literal spot checks.
module tb_arbitro_escritura_breg;

    localparam int unsigned ANCHO = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_a, req_m, reserva;
    logic [4:0]       dir_a, dir_m, dirres, dirlec1, dirlec2;
    logic [ANCHO-1:0] dato_a, dato_m;
    logic             ack_a, ack_m, ocupado1, ocupado2, enesc, err_sin_reserva;
    logic [4:0]       diresc;
    logic [ANCHO-1:0] datoesc;

    int errors = 0;
    int checks = 0;

    arbitro_escritura_breg #(.ANCHO(ANCHO), .NREG(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .req_a           (req_a),
        .dir_a           (dir_a),
        .dato_a          (dato_a),
        .ack_a           (ack_a),
        .req_m           (req_m),
        .dir_m           (dir_m),
        .dato_m          (dato_m),
        .ack_m           (ack_m),
        .reserva         (reserva),
        .dirres          (dirres),
        .dirlec1         (dirlec1),
        .dirlec2         (dirlec2),
        .ocupado1        (ocupado1),
        .ocupado2        (ocupado2),
        .enesc           (enesc),
        .diresc          (diresc),
        .datoesc         (datoesc),
        .err_sin_reserva (err_sin_reserva)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: what each output must be during the current cycle.
    bit             m_valid = 1'b0;
    bit             m_ack_a, m_ack_m, m_en, m_err, m_ptr_m;
    bit [4:0]       m_dir;
    bit [ANCHO-1:0] m_dat;
    bit [31:0]      m_sb;

    always @(negedge clk) begin
        int             winner;  // 0 none, 1 A, 2 M
        bit             ea, em;
        bit [4:0]       wdir;
        bit [ANCHO-1:0] wdat;
        bit [31:0]      nsb;
        if (m_valid) begin
            chk("ack_a", ack_a, m_ack_a);
            chk("ack_m", ack_m, m_ack_m);
            chk("enesc", enesc, m_en);
            chk("diresc", diresc, m_dir);
            chk("datoesc", datoesc, m_dat);
            chk("err_sin_reserva", err_sin_reserva, m_err);
            chk("ocupado1", ocupado1, m_sb[dirlec1]);
            chk("ocupado2", ocupado2, m_sb[dirlec2]);
        end
        if (rst) begin
            m_valid = 1'b1;
            m_ack_a = 0; m_ack_m = 0; m_en = 0; m_err = 0; m_ptr_m = 0;
            m_dir = 0; m_dat = 0; m_sb = 0;
        end else if (m_valid) begin
            ea = req_a && !m_ack_a;
            em = req_m && !m_ack_m;
            winner = 0;
            if (ea && em) begin
`ifdef ARBITRO_RR_EN
                winner = m_ptr_m ? 2 : 1;
`else
                winner = 1;
`endif
            end else if (ea) begin
                winner = 1;
            end else if (em) begin
                winner = 2;
            end
            wdir = (winner == 1) ? dir_a : dir_m;
            wdat = (winner == 1) ? dato_a : dato_m;
            nsb = m_sb;
            if (m_en) nsb[m_dir] = 1'b0;
            if (reserva && dirres != 0) nsb[dirres] = 1'b1;
            if (winner != 0 && wdir != 0 && !m_sb[wdir]) m_err = 1'b1;
            m_ack_a = (winner == 1);
            m_ack_m = (winner == 2);
            m_en    = (winner != 0) && (wdir != 0);
            if (winner != 0) begin
                m_dir = wdir;
                m_dat = wdat;
                m_ptr_m = (winner == 1);
            end
            m_sb = nsb;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1; req_a = 0; req_m = 0; reserva = 0;
        dir_a = 0; dir_m = 0; dirres = 0; dirlec1 = 0; dirlec2 = 0;
        dato_a = 0; dato_m = 0;
        step(); step();
        chk("rst enesc", enesc, 0);
        chk("rst ack_a", ack_a, 0);
        chk("rst diresc", diresc, 0);
        chk("rst datoesc", datoesc, 0);
        rst = 0;

        // Both requesters together: A first, then M on the following edge.
        reserva = 1; dirres = 3; step();
        dirres = 4; step();
        reserva = 0;
        req_a = 1; dir_a = 3; dato_a = 32'h11;
        req_m = 1; dir_m = 4; dato_m = 32'h22;
        step();
        chk("both ack_a", ack_a, 1);
        chk("both ack_m", ack_m, 0);
        chk("both diresc A", diresc, 3);
        chk("both datoesc A", datoesc, 32'h11);
        req_a = 0; step();
        chk("both ack_m 2nd", ack_m, 1);
        chk("both ack_a 2nd", ack_a, 0);
        chk("both diresc M", diresc, 4);
        chk("both datoesc M", datoesc, 32'h22);
        chk("both enesc M", enesc, 1);
        req_m = 0; step();
        chk("idle enesc", enesc, 0);

        // Reserved write to r5; ocupado1 high through the write cycle.
        reserva = 1; dirres = 5; dirlec1 = 5; step();
        reserva = 0;
        chk("r5 reserved", ocupado1, 1);
        req_a = 1; dir_a = 5; dato_a = 32'hDEADBEEF; step();
        chk("r5 ack_a", ack_a, 1);
        chk("r5 enesc", enesc, 1);
        chk("r5 diresc", diresc, 5);
        chk("r5 datoesc", datoesc, 32'hDEADBEEF);
        chk("r5 ocupado during write", ocupado1, 1);
        req_a = 0; step();
        chk("r5 enesc after", enesc, 0);
        chk("r5 ocupado after", ocupado1, 0);

        // Load to r0: acked, no write, no error.
        req_m = 1; dir_m = 0; dato_m = 32'h55; step();
        chk("r0 ack_m", ack_m, 1);
        chk("r0 enesc", enesc, 0);
        chk("r0 datoesc", datoesc, 32'h55);
        chk("r0 err", err_sin_reserva, 0);
        req_m = 0; step();

        // Re-reservation of r9 on the edge that clears it: set wins.
        reserva = 1; dirres = 9; step();
        reserva = 0;
        req_a = 1; dir_a = 9; dato_a = 32'h99; step();
        chk("r9 enesc", enesc, 1);
        req_a = 0; reserva = 1; dirres = 9; dirlec1 = 9; step();
        reserva = 0;
        chk("r9 set wins", ocupado1, 1);
        chk("r9 enesc after", enesc, 0);
        chk("r9 err", err_sin_reserva, 0);

        // Unreserved write to r7: performed, sticky error.
        req_a = 1; dir_a = 7; dato_a = 32'h77; step();
        chk("r7 enesc", enesc, 1);
        chk("r7 ack_a", ack_a, 1);
        chk("r7 err", err_sin_reserva, 1);
        req_a = 0; step(); step();
        chk("r7 err sticky", err_sin_reserva, 1);

        // Reset on the edge where a grant would happen.
        reserva = 1; dirres = 12; dirlec2 = 12; step();
        reserva = 0;
        chk("r12 reserved", ocupado2, 1);
        req_a = 1; dir_a = 12; dato_a = 32'hAA; rst = 1; step();
        rst = 0;
        chk("rstmid enesc", enesc, 0);
        chk("rstmid ack_a", ack_a, 0);
        chk("rstmid ack_m", ack_m, 0);
        chk("rstmid sb", ocupado2, 0);
        chk("rstmid err", err_sin_reserva, 0);
        step();
        chk("post-rst ack_a", ack_a, 1);
        req_a = 0; step(); step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/arbitro_escritura_breg.md
# arbitro_escritura_breg

Write-port arbiter and scoreboard for the 32×32 register file. Two write-back requesters, the ALU path (A) and the memory-load path (M), compete for the single register-file write port. The block grants one per cycle and drives the registered `enesc`/`diresc`/`datoesc` port. It also keeps a 32-bit pending-write scoreboard that the issue stage sets and queries to detect RAW hazards on the two read addresses.

## Interface
Parameters:
- `ANCHO`, 32, data width of the write port.
- `NREG`, 32, number of registers; address width is fixed at 5.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_a` in 1: ALU write request; held with `dir_a`/`dato_a` stable until `ack_a`.
- `dir_a` in 5: ALU destination register.
- `dato_a` in ANCHO: ALU write data.
- `ack_a` out 1: one-cycle pulse, ALU request accepted.
- `req_m` in 1: load write request; same hold rule as `req_a`.
- `dir_m` in 5: load destination register.
- `dato_m` in ANCHO: load write data.
- `ack_m` out 1: one-cycle pulse, load request accepted.
- `reserva` in 1: issue stage reserves destination `dirres`.
- `dirres` in 5: register to mark pending.
- `dirlec1` in 5: first read address to check.
- `dirlec2` in 5: second read address to check.
- `ocupado1` out 1: combinational; scoreboard bit of `dirlec1`.
- `ocupado2` out 1: combinational; scoreboard bit of `dirlec2`.
- `enesc` out 1: register-file write enable (registered).
- `diresc` out 5: register-file write address (registered).
- `datoesc` out ANCHO: register-file write data (registered).
- `err_sin_reserva` out 1: sticky; a commit targeted an unreserved nonzero register.

## Operation
**Eligibility.** A requester is eligible at an edge when its `req` is high and its `ack` is currently low. A requester is never granted twice on consecutive edges.

**Grant.** At most one grant per edge.
- Fixed priority: A over M.
- Round-robin option: see Configuration.

**On grant of requester X at edge N:**
- `ack_X`=1 for cycle N+1.
- `diresc`=`dir_X` and `datoesc`=`dato_X` for cycle N+1.
- `enesc`=1 for cycle N+1 if `dir_X`≠0. If `dir_X`=0, the request is still acked but `enesc` stays 0 (r0 is never written).
- If no grant occurs at an edge: `enesc`=0 and both acks are 0 in the next cycle; `diresc`/`datoesc` hold their last values.

**Scoreboard** (`sb[31:0]`, `sb[0]` permanently 0):
- Set: `reserva`=1 with `dirres`≠0 sets `sb[dirres]` at the edge.
- Clear: the bit for `diresc` clears at the edge that ends a cycle with `enesc`=1, so `ocupado` stays high through the write cycle itself.
- Set and clear of the same bit at the same edge: set wins.
- Error flag: a grant whose `dir_X`≠0 while `sb[dir_X]`=0 sets `err_sin_reserva`. The flag clears only on `rst`.

**States** (pointer state exists only when round-robin is compiled in):
- LIBRE: no write in flight.
- ESCRIBE: `enesc` cycle active.
- Transitions:
  - LIBRE→ESCRIBE on a grant with nonzero `dir`.
  - ESCRIBE→ESCRIBE on a back-to-back grant.
  - ESCRIBE→LIBRE when there is no grant.

## Timing
- Grant latency: `req` sampled at edge N; `ack` and write asserted in cycle N+1. The register file captures the data during that cycle.
- Throughput: one write per cycle overall; one write per two cycles per requester.
- Reset (synchronous, `rst`=1 at an edge) sets:
  - `enesc`=0, `ack_a`=0, `ack_m`=0.
  - `diresc`=0, `datoesc`=0.
  - `sb`=0, `err_sin_reserva`=0, round-robin pointer=A.
- Reset mid-write: the pending write cycle is cancelled. `enesc` is 0 in the cycle after the reset edge, and no ack is issued.
- `ocupado1`/`ocupado2` reflect `sb` combinationally. They do not see a same-cycle `reserva`; that takes effect after the edge.

## Configuration
`ARBITRO_RR_EN`:
- Defined: round-robin. A 1-bit pointer names the preferred requester. After a grant to X, the pointer moves to the other requester. When both are eligible, the pointer's requester wins.
- Undefined: fixed priority, A always wins. No pointer register exists.

## Test plan
- Reset, then `reserva`/`dirres`=5; next cycle `req_a`, `dir_a`=5, `dato_a`=0xDEADBEEF → one cycle later `ack_a`=1, `enesc`=1, `diresc`=5, `datoesc`=0xDEADBEEF. `ocupado1` for `dirlec1`=5 is high through the write cycle and low after.
- `req_a` and `req_m` held together, A→r3 (0x11), M→r4 (0x22) → without `ARBITRO_RR_EN`: A granted first, M on the next edge (consecutive-grant rule). With the macro defined, starting from pointer=A: the same A-then-M order.
- `req_m` with `dir_m`=0, `dato_m`=0x55 → `ack_m`=1, `enesc`=0, `err_sin_reserva` stays 0.
- `req_a` to r7 without a prior reservation → write performed, `err_sin_reserva`=1 and it stays set until `rst`.
- `reserva` to r9 on the same edge that clears r9 → `sb[9]`=1 afterwards, so `ocupado1` with `dirlec1`=9 reads 1.
- `rst` asserted in the cycle a grant is pending → `enesc`=0, acks=0, `sb`=0 in the following cycle.
